dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
// Shares the single CPU->dcache request port between the load/store unit (requester 0, LSU)
// and the page-table walker (requester 1, PTW). Fixed priority to PTW with an anti-starvation
// override for LSU; holds each grant until the dcache accepts it.
// Rewrites the 7-bit request tag so the MSB names the owner, and routes responses back by that bit.
// Sits between the exe-stage memory unit / PTW and the dcache interface.
// PARAMETERS
// STARVE_LIMIT   8   consecutive LSU-lost arbitration cycles before LSU is forced to win
// MAX_OUTST      4   max in-flight (accepted, unanswered) requests per requester
// PORTS
// clk_i            in   1                  clock
// rstn_i           in   1                  asynchronous active-low reset
// flush_i          in   1                  pipeline flush (clears starvation counter only)
// lsu_req_i        in   req_cpu_dcache_t   LSU request; rd[5:0] is LSU-local tag
// lsu_ready_o      out  1                  LSU request accepted this cycle
// lsu_resp_o       out  resp_dcache_cpu_t  response routed to LSU, rd[6] forced to 0
// ptw_req_i        in   req_cpu_dcache_t   PTW request; rd[5:0] is PTW-local tag
// ptw_ready_o      out  1                  PTW request accepted this cycle
// ptw_resp_o       out  resp_dcache_cpu_t  response routed to PTW, rd[6] forced to 0
// dc_req_o         out  req_cpu_dcache_t   request to dcache
// dc_resp_i        in   resp_dcache_cpu_t  dcache response; .ready = request accepted
// BEHAVIOUR
// - Reset: state IDLE, starve_cnt=0, both outstanding counters=0; dc_req_o.valid, *_ready_o,
//   *_resp_o.valid all 0 (request outputs combinational, therefore 0 whenever IDLE w/o valid input).
// - FSM: IDLE, LOCK_LSU, LOCK_PTW. In IDLE, choose winner combinationally among eligible
//   requesters (valid & outst_cnt<MAX_OUTST): PTW wins unless starve_cnt==STARVE_LIMIT.
//   Winner is driven to dc_req_o in the same cycle (0-cycle latency).
//   If dc_resp_i.ready that cycle: accept, stay IDLE; else go to LOCK_<winner>.
// - LOCK_x: dc_req_o driven only from x, no re-arbitration; return to IDLE on dc_resp_i.ready.
//   If x drops valid while locked (killed request), return to IDLE next cycle, no accept counted.
// - Accept = dc_req_o.valid & dc_resp_i.ready; x_ready_o=1 only for owner on accept.
// - Tag: dc_req_o.rd = {owner, x_req_i.rd[5:0]} (owner LSU=0, PTW=1); all other fields pass through.
// - Response: dc_resp_i.valid with rd[6]==0 -> lsu_resp_o.valid, else ptw_resp_o.valid; the other
//   output valid=0; data/xcpt fanned to both; ready field of each *_resp_o = that requester's ready.
// - outst_cnt[x]: +1 on x accept, -1 on x response; same-cycle accept+response -> unchanged.
//   Saturates never: at MAX_OUTST requester is ineligible; response with count 0 is an error
//   (assertion), count held at 0.
// - starve_cnt: +1 each IDLE cycle LSU is eligible and loses; cleared on LSU accept or flush_i;
//   saturates at STARVE_LIMIT.
// - Reset mid-lock: async to IDLE, counters 0; in-flight responses after reset are dropped by
//   consumers (arbiter still routes them by rd[6]).
// - Both invalid in IDLE: dc_req_o.valid=0, no state change.
// STRUCTURE
// - drac_pkg: arb_state_t enum, ARB_OWNER_LSU/ARB_OWNER_PTW constants, DC_TAG_OWNER_BIT=6.
// - One sub-module natural: arb_outst_counter (up/down counter with limit flag), instanced x2.
// - Arbitration/lock FSM and response demux stay in top level.
// TESTING
// 1 Both valid in IDLE, ready=1: dc_req_o.rd=={1,ptw.rd[5:0]}, ptw_ready_o=1, lsu_ready_o=0.
// 2 LSU+PTW valid 9 cycles, ready=1 always, STARVE_LIMIT=8: cycles 0-7 PTW, cycle 8 LSU, cnt->0.
// 3 LSU valid, ready=0 for 3 cycles then PTW asserts: dc_req_o stays LSU until ready, LOCK_LSU held.
// 4 4 PTW accepts, no responses: 5th PTW valid ineligible, LSU valid gets grant; resp rd=7'h41 -> PTW count 3.
// 5 dc_resp valid rd=7'h05 -> lsu_resp_o.valid=1 rd=5, ptw_resp_o.valid=0; rd=7'h45 -> PTW side.
// 6 rstn_i low during LOCK_PTW: outputs 0 immediately, state IDLE, counters 0 after release.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and constants for the dcache request-port arbiter.
package dcache_port_arbiter_pkg;

  // CPU -> dcache request
  typedef struct packed {
    logic        valid;
    logic [39:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic        is_store;
    logic [6:0]  rd;
  } req_cpu_dcache_t;

  // dcache -> CPU response; ready means the request on the port was accepted
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic        xcpt;
    logic [6:0]  rd;
  } resp_dcache_cpu_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_LOCK_LSU = 2'd1,
    ARB_LOCK_PTW = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_LSU    = 1'b0;
  localparam logic ARB_OWNER_PTW    = 1'b1;
  localparam int   DC_TAG_OWNER_BIT = 6;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned MAX_OUTST_DEF    = 4;

endpackage

// File: rtl/dcache_port_arbiter_outst_counter.sv
// Up/down counter of in-flight requests for one requester, with a full flag
// that makes the requester ineligible for arbitration.
module dcache_port_arbiter_outst_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: simultaneous inc/dec cancel; a decrement at zero is held at zero
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == W'(LIMIT));

`ifndef SYNTHESIS
  // A response for a requester with nothing in flight means a tag got corrupted
  a_no_resp_at_zero: assert property (@(posedge clk_i) disable iff (!rstn_i)
    dec_i |-> (cnt_q != '0));
`endif

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the dcache request port between LSU and PTW: fixed priority to PTW
// with an LSU anti-starvation override, grant held until accepted, owner bit
// folded into the request tag and used to route responses back.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned MAX_OUTST    = MAX_OUTST_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  req_cpu_dcache_t  lsu_req_i,
  output logic             lsu_ready_o,
  output resp_dcache_cpu_t lsu_resp_o,
  input  req_cpu_dcache_t  ptw_req_i,
  output logic             ptw_ready_o,
  output resp_dcache_cpu_t ptw_resp_o,
  output req_cpu_dcache_t  dc_req_o,
  input  resp_dcache_cpu_t dc_resp_i
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned OUTST_W  = $clog2(MAX_OUTST + 1);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [OUTST_W-1:0]  lsu_cnt, ptw_cnt;
  logic                lsu_full, ptw_full;
  logic                lsu_elig, ptw_elig, starve_at_limit;
  logic                grant_lsu, grant_ptw;
  logic                lsu_accept, ptw_accept;
  logic                lsu_resp_hit, ptw_resp_hit;

  assign lsu_elig        = lsu_req_i.valid & ~lsu_full;
  assign ptw_elig        = ptw_req_i.valid & ~ptw_full;
  assign starve_at_limit = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign lsu_accept      = grant_lsu & dc_resp_i.ready;
  assign ptw_accept      = grant_ptw & dc_resp_i.ready;
  assign lsu_resp_hit    = dc_resp_i.valid & ~dc_resp_i.rd[DC_TAG_OWNER_BIT];
  assign ptw_resp_hit    = dc_resp_i.valid &  dc_resp_i.rd[DC_TAG_OWNER_BIT];

  // State and starvation counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next state: lock onto an unaccepted winner, release on accept or kill
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_ptw && !dc_resp_i.ready) begin
          state_d = ARB_LOCK_PTW;
        end else if (grant_lsu && !dc_resp_i.ready) begin
          state_d = ARB_LOCK_LSU;
        end
      end
      ARB_LOCK_LSU: if (!lsu_req_i.valid || dc_resp_i.ready) state_d = ARB_IDLE;
      ARB_LOCK_PTW: if (!ptw_req_i.valid || dc_resp_i.ready) state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  // Outputs: pick the grant, drive the dcache port with the owner-tagged request
  always_comb begin
    grant_lsu = 1'b0;
    grant_ptw = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (ptw_elig && !(lsu_elig && starve_at_limit)) begin
          grant_ptw = 1'b1;
        end else if (lsu_elig) begin
          grant_lsu = 1'b1;
        end
      end
      ARB_LOCK_LSU: grant_lsu = lsu_req_i.valid;
      ARB_LOCK_PTW: grant_ptw = ptw_req_i.valid;
      default: ;
    endcase
    dc_req_o       = grant_ptw ? ptw_req_i : lsu_req_i;
    dc_req_o.valid = grant_lsu | grant_ptw;
    dc_req_o.rd    = grant_ptw ? {ARB_OWNER_PTW, ptw_req_i.rd[5:0]}
                               : {ARB_OWNER_LSU, lsu_req_i.rd[5:0]};
    lsu_ready_o    = lsu_accept;
    ptw_ready_o    = ptw_accept;
  end

  // Starvation counter: counts IDLE cycles where an eligible LSU lost
  always_comb begin
    starve_d = starve_q;
    if ((state_q == ARB_IDLE) && lsu_elig && !grant_lsu && !starve_at_limit) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    if (flush_i || lsu_accept) begin
      starve_d = '0;
    end
  end

  // Response demux by the owner bit; payload fans out to both sides
  always_comb begin
    lsu_resp_o                      = dc_resp_i;
    lsu_resp_o.valid                = lsu_resp_hit;
    lsu_resp_o.ready                = lsu_ready_o;
    lsu_resp_o.rd[DC_TAG_OWNER_BIT] = 1'b0;
    ptw_resp_o                      = dc_resp_i;
    ptw_resp_o.valid                = ptw_resp_hit;
    ptw_resp_o.ready                = ptw_ready_o;
    ptw_resp_o.rd[DC_TAG_OWNER_BIT] = 1'b0;
  end

  dcache_port_arbiter_outst_counter #(.LIMIT(MAX_OUTST), .W(OUTST_W)) u_lsu_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .inc_i  (lsu_accept),
    .dec_i  (lsu_resp_hit),
    .cnt_o  (lsu_cnt),
    .full_o (lsu_full)
  );

  dcache_port_arbiter_outst_counter #(.LIMIT(MAX_OUTST), .W(OUTST_W)) u_ptw_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .inc_i  (ptw_accept),
    .dec_i  (ptw_resp_hit),
    .cnt_o  (ptw_cnt),
    .full_o (ptw_full)
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: stimulus pushes expected port
// activity, a negedge monitor pops and compares whenever the DUT shows any
// valid output.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  logic             clk;
  logic             rstn;
  logic             flush;
  req_cpu_dcache_t  lsu_req, ptw_req, dc_req;
  resp_dcache_cpu_t lsu_resp, ptw_resp, dc_resp;
  logic             lsu_ready, ptw_ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       req_v;
    logic [6:0] req_rd;
    logic [7:0] req_addr;
    logic       lsu_rdy;
    logic       ptw_rdy;
    logic       lsu_rv;
    logic       ptw_rv;
    logic [6:0] resp_rd;
    logic [7:0] resp_dat;
  } exp_t;

  exp_t exp_q[$];

  dcache_port_arbiter #(.STARVE_LIMIT(8), .MAX_OUTST(4)) u_dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .flush_i     (flush),
    .lsu_req_i   (lsu_req),
    .lsu_ready_o (lsu_ready),
    .lsu_resp_o  (lsu_resp),
    .ptw_req_i   (ptw_req),
    .ptw_ready_o (ptw_ready),
    .ptw_resp_o  (ptw_resp),
    .dc_req_o    (dc_req),
    .dc_resp_i   (dc_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected request on the dcache port
  function automatic exp_t x_req(input logic owner, input logic [5:0] tag, input logic acc);
    exp_t e;
    e          = '0;
    e.req_v    = 1'b1;
    e.req_rd   = {owner, tag};
    e.req_addr = {(owner ? 4'hB : 4'hA), tag[3:0]};
    e.lsu_rdy  = acc & ~owner;
    e.ptw_rdy  = acc & owner;
    return e;
  endfunction

  // Add an expected routed response to an entry
  function automatic exp_t x_resp(input exp_t base, input logic [6:0] rrd);
    exp_t e;
    e          = base;
    e.lsu_rv   = ~rrd[6];
    e.ptw_rv   = rrd[6];
    e.resp_rd  = {1'b0, rrd[5:0]};
    e.resp_dat = 8'hD0 ^ {1'b0, rrd};
    return e;
  endfunction

  task automatic set_in(input logic lv, input logic [5:0] lt, input logic pv, input logic [5:0] pt,
                        input logic rdy, input logic rv, input logic [6:0] rrd, input logic fl);
    lsu_req          = '0;
    lsu_req.valid    = lv;
    lsu_req.addr     = {32'h0, 4'hA, lt[3:0]};
    lsu_req.rd       = {1'b1, lt};
    ptw_req          = '0;
    ptw_req.valid    = pv;
    ptw_req.addr     = {32'h0, 4'hB, pt[3:0]};
    ptw_req.rd       = {1'b0, pt};
    dc_resp          = '0;
    dc_resp.ready    = rdy;
    dc_resp.valid    = rv;
    dc_resp.rd       = rrd;
    dc_resp.data     = {56'h0, 8'hD0 ^ {1'b0, rrd}};
    flush            = fl;
  endtask

  task automatic cyc(input exp_t e);
    if (e != '0) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // Monitor: whenever the DUT shows any valid output, pop and compare
  always @(negedge clk) begin
    exp_t act, e;
    act          = '0;
    act.req_v    = dc_req.valid;
    act.req_rd   = dc_req.valid ? dc_req.rd : 7'h0;
    act.req_addr = dc_req.valid ? dc_req.addr[7:0] : 8'h0;
    act.lsu_rdy  = lsu_ready;
    act.ptw_rdy  = ptw_ready;
    act.lsu_rv   = lsu_resp.valid;
    act.ptw_rv   = ptw_resp.valid;
    act.resp_rd  = lsu_resp.valid ? lsu_resp.rd : (ptw_resp.valid ? ptw_resp.rd : 7'h0);
    act.resp_dat = lsu_resp.valid ? lsu_resp.data[7:0] : (ptw_resp.valid ? ptw_resp.data[7:0] : 8'h0);
    if (act.req_v || act.lsu_rdy || act.ptw_rdy || act.lsu_rv || act.ptw_rv) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h want none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL port_txn got %h want %h", act, e);
        end else begin
          $display("txn ok %h", act);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 7'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dc_valid", 64'(dc_req.valid), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst_ptw_ready", 64'(ptw_ready), 64'd0);
    chk("rst_resp_valid", 64'({lsu_resp.valid, ptw_resp.valid}), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Both valid in IDLE: PTW wins, tag owner bit set
    set_in(1, 6'd3, 1, 6'd5, 1, 0, 7'h0, 0);
    cyc(x_req(1, 6'd5, 1));
    // PTW response rd 0x45, owner bit stripped; flush clears starvation
    set_in(0, 0, 0, 0, 0, 1, 7'h45, 1);
    cyc(x_resp('0, 7'h45));

    // Starvation: 8 PTW wins, then LSU forced; PTW responses keep it eligible
    for (int k = 0; k < 9; k++) begin
      exp_t e;
      set_in(1, 6'h10, 1, 6'(32 + k), 1, (k >= 1), {1'b1, 6'(k)}, 0);
      e = (k < 8) ? x_req(1, 6'(32 + k), 1) : x_req(0, 6'h10, 1);
      if (k >= 1) e = x_resp(e, {1'b1, 6'(k)});
      cyc(e);
    end
    set_in(0, 0, 0, 0, 0, 1, 7'h10, 0);
    cyc(x_resp('0, 7'h10));

    // LSU locked while ready low; PTW arrival does not re-arbitrate
    for (int k = 0; k < 4; k++) begin
      set_in(1, 6'd2, (k == 3), 6'd7, 0, 0, 7'h0, 0);
      cyc(x_req(0, 6'd2, 0));
    end
    set_in(1, 6'd2, 1, 6'd7, 1, 0, 7'h0, 0);
    cyc(x_req(0, 6'd2, 1));
    set_in(0, 0, 1, 6'd7, 1, 0, 7'h0, 0);
    cyc(x_req(1, 6'd7, 1));

    // Killed LSU request while locked: no request, back to IDLE next cycle
    set_in(1, 6'd3, 0, 0, 0, 0, 7'h0, 0);
    cyc(x_req(0, 6'd3, 0));
    set_in(0, 0, 1, 6'd8, 1, 1, 7'h02, 0);
    cyc(x_resp('0, 7'h02));
    set_in(0, 0, 1, 6'd8, 1, 1, 7'h47, 0);
    cyc(x_resp(x_req(1, 6'd8, 1), 7'h47));
    set_in(0, 0, 0, 0, 0, 1, 7'h48, 0);
    cyc(x_resp('0, 7'h48));

    // Outstanding limit: 4 PTW accepts make PTW ineligible
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, 6'(8 + k), 1, 0, 7'h0, 0);
      cyc(x_req(1, 6'(8 + k), 1));
    end
    set_in(1, 6'd5, 1, 6'd12, 1, 0, 7'h0, 0);
    cyc(x_req(0, 6'd5, 1));
    set_in(0, 0, 0, 0, 0, 1, 7'h41, 0);
    cyc(x_resp('0, 7'h41));
    set_in(1, 6'd6, 1, 6'd13, 1, 0, 7'h0, 0);
    cyc(x_req(1, 6'd13, 1));
    set_in(1, 6'd6, 1, 6'd14, 1, 0, 7'h0, 0);
    cyc(x_req(0, 6'd6, 1));
    // Drain: LSU rd 0x05/0x06, PTW 0x48..0x4B
    set_in(0, 0, 0, 0, 0, 1, 7'h05, 0);
    cyc(x_resp('0, 7'h05));
    set_in(0, 0, 0, 0, 0, 1, 7'h06, 0);
    cyc(x_resp('0, 7'h06));
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 0, 0, 0, 1, 7'(8'h48 + k), 0);
      cyc(x_resp('0, 7'(8'h48 + k)));
    end

    // Reset during LOCK_PTW
    for (int k = 0; k < 3; k++) begin
      set_in(1, 6'd1, 1, 6'(k), 1, 0, 7'h0, 0);
      cyc(x_req(1, 6'(k), 1));
    end
    set_in(1, 6'd1, 1, 6'd3, 0, 0, 7'h0, 0);
    cyc(x_req(1, 6'd3, 0));
    set_in(0, 0, 0, 0, 0, 0, 7'h0, 0);
    rstn = 1'b0;
    #1;
    chk("midrst_dc_valid", 64'(dc_req.valid), 64'd0);
    chk("midrst_ready", 64'({lsu_ready, ptw_ready}), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // After reset: IDLE (LSU served), PTW count back to 0 (4 accepts allowed)
    set_in(1, 6'd4, 0, 0, 1, 0, 7'h0, 0);
    cyc(x_req(0, 6'd4, 1));
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, 6'(k), 1, 0, 7'h0, 0);
      cyc(x_req(1, 6'(k), 1));
    end
    set_in(1, 6'd5, 1, 6'd9, 1, 0, 7'h0, 0);
    cyc(x_req(0, 6'd5, 1));

    set_in(0, 0, 0, 0, 0, 0, 7'h0, 0);
    repeat (3) cyc('0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
